// File: rtl/instruction_fetch.sv
// Program-execution front end: fetches words from a synchronous instruction memory and hands
// them one at a time to the core via a start/busy handshake. Define FETCH_WATCHDOG_EN for the handshake watchdog.
module instruction_fetch #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDR_WIDTH        = 8,
  parameter int START_ADDR        = 0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD = '0,
  parameter int WATCHDOG_CYCLES   = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         stop,
  output logic                         imem_rdEn,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic                         start,
  input  logic                         coreBusy,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic [15:0]                  retired,
  output logic                         active,
  output logic                         halted,
  output logic                         error
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    HALT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);

  state_t                         state, state_next;
  logic [ADDR_WIDTH-1:0]          pc_q;
  logic [15:0]                    retired_q;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q;
  logic                           stop_pending;
  logic                           load_run, capture, retire, advance_pc;
  logic                           wdog_trip;
  logic                           stop_seen;

  assign stop_seen = stop | stop_pending;

  always_comb begin
    state_next = state;
    load_run   = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    advance_pc = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (run) begin
          load_run   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH:    state_next = WAIT_MEM;
      WAIT_MEM: begin
        capture    = 1'b1;
        state_next = (imem_data == HALT_WORD) ? HALT : ISSUE;
      end
      ISSUE:    state_next = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (coreBusy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!coreBusy) begin
          retire = 1'b1;
          // The last address is the final executable word, so it halts instead of wrapping.
          if (stop_seen || (&pc_q)) begin
            state_next = HALT;
          end else begin
            advance_pc = 1'b1;
            state_next = FETCH;
          end
        end
      end
      default:  state_next = IDLE;
    endcase
    if (wdog_trip) begin
      state_next = HALT;
      retire     = 1'b0;
      advance_pc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc_q         <= START_PC;
      retired_q    <= '0;
      instr_q      <= '0;
      stop_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (load_run) begin
        pc_q         <= START_PC;
        retired_q    <= '0;
        stop_pending <= 1'b0;
      end else begin
        if (advance_pc) pc_q <= pc_q + 1'b1;
        if (retire && (retired_q != 16'hFFFF)) retired_q <= retired_q + 16'd1;
        if (stop && (state != IDLE) && (state != HALT)) stop_pending <= 1'b1;
      end
      if (capture) instr_q <= imem_data;
    end
  end

`ifdef FETCH_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              error_q;
  logic              in_wait;
  logic              wait_holds;

  assign in_wait    = (state == WAIT_ACCEPT) || (state == WAIT_DONE);
  assign wait_holds = ((state == WAIT_ACCEPT) && !coreBusy) || ((state == WAIT_DONE) && coreBusy);
  // The counter already holds WATCHDOG_CYCLES-1 on the last permitted wait cycle.
  assign wdog_trip  = wait_holds && (wdog_q == WDOG_W'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if ((state_next != state) &&
          ((state_next == WAIT_ACCEPT) || (state_next == WAIT_DONE))) begin
        wdog_q <= '0;
      end else if (in_wait) begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (load_run) begin
        error_q <= 1'b0;
      end else if (wdog_trip) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign wdog_trip = 1'b0;
  assign error     = 1'b0;
`endif

  assign imem_rdEn      = (state == FETCH) && !reset;
  assign imem_addr      = pc_q;
  assign start          = (state == ISSUE) && !reset;
  assign instructionOut = instr_q;
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign active         = (state != IDLE) && (state != HALT);
  assign halted         = (state == HALT);

endmodule
